// File: rtl/aes128_package.sv
// Shared AES datapath definitions: masking helpers, randomness-source FSM states
// and the xorshift32 step used by both the lanes and the bench model.
package aes128_package;

  typedef enum logic [1:0] {
    RS_SEED,
    RS_WARMUP,
    RS_RUN
  } rand_state_t;

  // Number of share pairs, i.e. fresh-mask bits one HPC3 gadget consumes per input.
  function automatic int num_quad(input int num_shares);
    return (num_shares * (num_shares - 1)) / 2;
  endfunction

  function automatic int rand_lanes(input int num_shares, input int num_muls);
    return ((2 * num_muls * num_quad(num_shares)) + 31) / 32;
  endfunction

  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/masked_mul_rand_source_lane.sv
// One xorshift32 lane: loadable 32-bit state that advances one step when asked.
module xorshift32_lane
  import aes128_package::*;
(
  input  logic        in_clock,
  input  logic        in_reset,
  input  logic        in_load,
  input  logic [31:0] in_seed,
  input  logic        in_step,
  output logic [31:0] out_state
);

  logic [31:0] state_q;

  // A zero seed would lock xorshift at zero forever, so it is replaced by 1.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q <= '0;
    end else if (in_load) begin
      state_q <= (in_seed == 32'h0) ? 32'h1 : in_seed;
    end else if (in_step) begin
      state_q <= xorshift32_step(state_q);
    end
  end

  assign out_state = state_q;

endmodule

// File: rtl/masked_mul_rand_source.sv
// Seedable xorshift32 bank feeding r/p fresh masks of parallel HPC3 multipliers.
// Masks are taken directly from lane registers; the FSM only gates load/step.
module masked_mul_rand_source
  import aes128_package::*;
#(
  parameter int NUM_SHARES    = 2,
  parameter int NUM_MULS      = 1,
  parameter int WARMUP_CYCLES = 4,
  localparam int NQ        = num_quad(NUM_SHARES),
  localparam int OUT_BITS  = 2 * NUM_MULS * NQ,
  localparam int NUM_LANES = rand_lanes(NUM_SHARES, NUM_MULS)
) (
  input  logic                             in_clock,
  input  logic                             in_reset,
  input  logic [31:0]                      in_seed,
  input  logic                             in_seed_valid,
  output logic                             out_seed_ready,
  input  logic                             in_reseed,
  input  logic                             in_enable,
  output logic [NUM_MULS-1:0][NQ-1:0]      out_r,
  output logic [NUM_MULS-1:0][NQ-1:0]      out_p,
  output logic                             out_valid
);

  localparam int CNT_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int WCNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

  rand_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               seed_accept;
  logic               lane_step;
  logic [NUM_LANES-1:0]    lane_load;
  logic [32*NUM_LANES-1:0] bits;
  logic                    unused_bits;

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q <= RS_SEED;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Reseed wins over enable so a reseed request never consumes a step.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    seed_accept = 1'b0;
    lane_step   = 1'b0;
    case (state_q)
      RS_SEED: begin
        if (in_seed_valid) begin
          seed_accept = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_LANES - 1)) begin
            cnt_d = '0;
            if (WARMUP_CYCLES == 0) begin
              state_d = RS_RUN;
            end else begin
              state_d = RS_WARMUP;
              wcnt_d  = WCNT_W'(WARMUP_CYCLES);
            end
          end
        end
      end
      RS_WARMUP: begin
        lane_step = 1'b1;
        wcnt_d    = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) begin
          state_d = RS_RUN;
        end
      end
      RS_RUN: begin
        if (in_reseed) begin
          state_d = RS_SEED;
          cnt_d   = '0;
        end else begin
          lane_step = in_enable;
        end
      end
      default: begin
        state_d = RS_SEED;
        cnt_d   = '0;
        wcnt_d  = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_load[i] = seed_accept && (cnt_q == CNT_W'(i));

    xorshift32_lane u_lane (
      .in_clock  (in_clock),
      .in_reset  (in_reset),
      .in_load   (lane_load[i]),
      .in_seed   (in_seed),
      .in_step   (lane_step),
      .out_state (bits[32*i +: 32])
    );
  end

  assign out_r          = bits[NUM_MULS*NQ-1:0];
  assign out_p          = bits[OUT_BITS-1:NUM_MULS*NQ];
  assign out_valid      = (state_q == RS_RUN);
  assign out_seed_ready = (state_q == RS_SEED);

  // High bits of the top lane keep stepping but never reach a mask input.
  assign unused_bits = ^bits;

endmodule

// File: tb/tb_masked_mul_rand_source.sv
// Directed bench: a 1-lane instance with 1-cycle warmup and a 2-lane instance
// (32 multipliers) with default warmup, checked against hand values and the model.
module tb_masked_mul_rand_source;
  import aes128_package::*;

  logic clock;

  logic        a_reset, a_seed_valid, a_reseed, a_enable;
  logic [31:0] a_seed;
  logic        a_seed_ready, a_valid;
  logic [0:0][0:0] a_r, a_p;

  logic        b_reset, b_seed_valid, b_reseed, b_enable;
  logic [31:0] b_seed;
  logic        b_seed_ready, b_valid;
  logic [31:0][0:0] b_r, b_p;

  int checks_done;
  int checks_failed;

  logic [31:0] m0, m1;

  localparam logic [31:0] S0 = 32'h12345678;
  localparam logic [31:0] S1 = 32'hDEADBEEF;
  localparam logic [31:0] S2 = 32'hCAFEF00D;

  masked_mul_rand_source #(
    .NUM_SHARES(2), .NUM_MULS(1), .WARMUP_CYCLES(1)
  ) dut_a (
    .in_clock(clock), .in_reset(a_reset), .in_seed(a_seed),
    .in_seed_valid(a_seed_valid), .out_seed_ready(a_seed_ready),
    .in_reseed(a_reseed), .in_enable(a_enable),
    .out_r(a_r), .out_p(a_p), .out_valid(a_valid)
  );

  masked_mul_rand_source #(
    .NUM_SHARES(2), .NUM_MULS(32), .WARMUP_CYCLES(4)
  ) dut_b (
    .in_clock(clock), .in_reset(b_reset), .in_seed(b_seed),
    .in_seed_valid(b_seed_valid), .out_seed_ready(b_seed_ready),
    .in_reseed(b_reseed), .in_enable(b_enable),
    .out_r(b_r), .out_p(b_p), .out_valid(b_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_done++;
    if (observed !== expected) begin
      checks_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs on the chosen instance, then return it to idle.
  task automatic applyStimulus(input bit to_b, input logic [31:0] seed,
                               input logic seed_valid, input logic reseed,
                               input logic enable);
    if (to_b) begin
      b_seed = seed; b_seed_valid = seed_valid; b_reseed = reseed; b_enable = enable;
    end else begin
      a_seed = seed; a_seed_valid = seed_valid; a_reseed = reseed; a_enable = enable;
    end
    @(negedge clock);
    if (to_b) begin
      b_seed = '0; b_seed_valid = 1'b0; b_reseed = 1'b0; b_enable = 1'b0;
    end else begin
      a_seed = '0; a_seed_valid = 1'b0; a_reseed = 1'b0; a_enable = 1'b0;
    end
  endtask

  function automatic logic [31:0] step_n(input logic [31:0] x, input int n);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = xorshift32_step(y);
    return y;
  endfunction

  // Seed both lanes of instance B back to back and confirm the warmup window.
  task automatic seed_b_full(input string tag);
    applyStimulus(1'b1, S0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, S1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_warm_valid"}, 64'(b_valid), 64'd0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
    end
    m0 = step_n(S0, 4);
    m1 = step_n(S1, 4);
    checkOutput({tag, "_valid"}, 64'(b_valid), 64'd1);
    checkOutput({tag, "_r"}, 64'(b_r), 64'(m0));
    checkOutput({tag, "_p"}, 64'(b_p), 64'(m1));
  endtask

  initial begin
    checks_done = 0;
    checks_failed = 0;
    a_reset = 1'b1; a_seed = '0; a_seed_valid = 1'b0; a_reseed = 1'b0; a_enable = 1'b0;
    b_reset = 1'b1; b_seed = '0; b_seed_valid = 1'b0; b_reseed = 1'b0; b_enable = 1'b0;
    repeat (2) @(negedge clock);
    a_reset = 1'b0;
    b_reset = 1'b0;

    checkOutput("rst_a_valid", 64'(a_valid), 64'd0);
    checkOutput("rst_a_ready", 64'(a_seed_ready), 64'd1);
    checkOutput("rst_a_rp", {62'd0, a_r, a_p}, 64'd0);
    checkOutput("rst_b_valid", 64'(b_valid), 64'd0);
    checkOutput("rst_b_ready", 64'(b_seed_ready), 64'd1);
    checkOutput("rst_b_rp", {b_r, b_p}, 64'd0);

    // Seed 1 with one warmup step gives lane 32'h00042021.
    applyStimulus(1'b0, 32'h1, 1'b1, 1'b0, 1'b0);
    checkOutput("a1_warm_valid", 64'(a_valid), 64'd0);
    checkOutput("a1_warm_ready", 64'(a_seed_ready), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("a1_valid", 64'(a_valid), 64'd1);
    checkOutput("a1_r", 64'(a_r), 64'd1);
    checkOutput("a1_p", 64'(a_p), 64'd0);

    // Zero seed behaves as seed 1.
    a_reset = 1'b1;
    @(negedge clock);
    a_reset = 1'b0;
    checkOutput("a2_rst_ready", 64'(a_seed_ready), 64'd1);
    checkOutput("a2_rst_r", 64'(a_r), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("a2_valid", 64'(a_valid), 64'd1);
    checkOutput("a2_r", 64'(a_r), 64'd1);
    checkOutput("a2_p", 64'(a_p), 64'd0);

    // Reseed together with enable: leave RUN without stepping, then reseed with 1.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("a3_reseed_valid", 64'(a_valid), 64'd0);
    checkOutput("a3_reseed_ready", 64'(a_seed_ready), 64'd1);
    applyStimulus(1'b0, 32'h1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("a3_valid", 64'(a_valid), 64'd1);
    checkOutput("a3_r", 64'(a_r), 64'd1);
    checkOutput("a3_p", 64'(a_p), 64'd0);

    // Two lanes with a 3-cycle gap between seed words.
    applyStimulus(1'b1, S0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("b_gap_ready", 64'(b_seed_ready), 64'd1);
      checkOutput("b_gap_valid", 64'(b_valid), 64'd0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, S1, 1'b1, 1'b0, 1'b0);
    checkOutput("b_seeded_ready", 64'(b_seed_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("b_warm_valid", 64'(b_valid), 64'd0);
    end
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
    m0 = step_n(S0, 4);
    m1 = step_n(S1, 4);
    checkOutput("b_valid", 64'(b_valid), 64'd1);
    checkOutput("b_r", 64'(b_r), 64'(m0));
    checkOutput("b_p", 64'(b_p), 64'(m1));

    // Enable pattern 1,0,1.
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1);
    m0 = xorshift32_step(m0); m1 = xorshift32_step(m1);
    checkOutput("b_en1_r", 64'(b_r), 64'(m0));
    checkOutput("b_en1_p", 64'(b_p), 64'(m1));
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("b_en0_r", 64'(b_r), 64'(m0));
    checkOutput("b_en0_p", 64'(b_p), 64'(m1));
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1);
    m0 = xorshift32_step(m0); m1 = xorshift32_step(m1);
    checkOutput("b_en2_r", 64'(b_r), 64'(m0));
    checkOutput("b_en2_p", 64'(b_p), 64'(m1));

    // Seed words in RUN are ignored.
    applyStimulus(1'b1, S2, 1'b1, 1'b0, 1'b0);
    checkOutput("b_ign_r", 64'(b_r), 64'(m0));
    checkOutput("b_ign_p", 64'(b_p), 64'(m1));
    checkOutput("b_ign_valid", 64'(b_valid), 64'd1);

    // Reseed beats enable: no step, handshake flips next cycle.
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("b_rs_valid", 64'(b_valid), 64'd0);
    checkOutput("b_rs_ready", 64'(b_seed_ready), 64'd1);
    checkOutput("b_rs_r", 64'(b_r), 64'(m0));
    checkOutput("b_rs_p", 64'(b_p), 64'(m1));

    // Reset after one of two seed words discards the partial seed.
    applyStimulus(1'b1, S2, 1'b1, 1'b0, 1'b0);
    checkOutput("b_part_r", 64'(b_r), 64'(S2));
    checkOutput("b_part_ready", 64'(b_seed_ready), 64'd1);
    b_reset = 1'b1;
    @(negedge clock);
    b_reset = 1'b0;
    checkOutput("b_mrst_rp", {b_r, b_p}, 64'd0);
    checkOutput("b_mrst_ready", 64'(b_seed_ready), 64'd1);
    checkOutput("b_mrst_valid", 64'(b_valid), 64'd0);
    seed_b_full("b_fresh");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             checks_done, checks_failed);
    $finish;
  end

endmodule

// File: doc/masked_mul_rand_source.md
# masked_mul_rand_source

Seedable randomness source that feeds the fresh-mask inputs (`in_r`, `in_p`) of a bank of masked HPC3 AND-gadget multipliers in the masked AES S-box datapath. It holds a bank of independent xorshift32 lanes that are loaded through a one-word-per-cycle seed handshake and warmed up for a fixed number of steps. Once running, it advances every cycle the datapath enables it. All mask bits come straight from lane registers, so no combinational logic sits between the state and the multiplier mask inputs.

## Interface
Parameters:
- `NUM_SHARES`, 2: share count of the fed multipliers; `NQ = num_quad(NUM_SHARES)`.
- `NUM_MULS`, 1: number of multipliers fed in parallel.
- `WARMUP_CYCLES`, 4: lane steps after seeding before output is valid; 0 allowed.
- Derived: `OUT_BITS = 2*NUM_MULS*NQ`, `NUM_LANES = ceil(OUT_BITS/32)`.

Ports:
- `in_clock` in 1: single clock, rising edge.
- `in_reset` in 1: synchronous, active-high reset.
- `in_seed` in 32: seed word.
- `in_seed_valid` in 1: seed word present.
- `out_seed_ready` out 1: block accepts seed words.
- `in_reseed` in 1: request to re-enter seeding, honoured only in RUN.
- `in_enable` in 1: advance lanes by one step in RUN.
- `out_r` out `NUM_MULS x NQ`: r masks, multiplier-major.
- `out_p` out `NUM_MULS x NQ`: p masks, multiplier-major.
- `out_valid` out 1: masks are seeded and warmed up.

## Operation
- Flat vector `bits = {lane[NUM_LANES-1], ..., lane[0]}`.
- `out_r[m][q] = bits[m*NQ+q]`.
- `out_p[m][q] = bits[NUM_MULS*NQ + m*NQ + q]`.
- Unused high bits of the top lane are still stepped.
- Lane step (xorshift32, 32-bit wrap): `x ^= x<<13; x ^= x>>17; x ^= x<<5`.
- FSM states:
  - SEED: `out_seed_ready=1`. On `in_seed_valid`, `lane[cnt] <= (in_seed==0) ? 32'h1 : in_seed` and `cnt++`. On the last lane, go to WARMUP with `wcnt=WARMUP_CYCLES`, or straight to RUN if `WARMUP_CYCLES=0`. Lanes do not step while in SEED.
  - WARMUP: all lanes step every cycle regardless of `in_enable`. `wcnt--`; go to RUN on the cycle `wcnt` reaches 1.
  - RUN: `out_valid=1`. Lanes step iff `in_enable`. If `in_reseed` is high, go to SEED with `cnt=0` and no step that cycle; reseed has priority over enable. Lanes keep their values until overwritten.
- `in_seed_valid` outside SEED is ignored, with no acceptance.
- `in_reseed` outside RUN is ignored.
- A zero seed word is replaced by 1, so no lane can ever be stuck at zero.

## Timing
- Reset values: state=SEED, all lanes 0, `cnt=0`, `wcnt=0`, `out_valid=0`, `out_seed_ready=1`, `out_r=0`, `out_p=0`.
- A seed word is accepted on a rising edge with `in_seed_valid & out_seed_ready`. Minimum seeding time is `NUM_LANES` cycles; gaps in `in_seed_valid` are allowed.
- `out_valid` rises `WARMUP_CYCLES` cycles after the edge that accepts the last seed word. It is registered from state.
- When `in_enable` is high in cycle k, new masks appear after edge k. Masks consumed in cycle k must not be reused.
- `out_valid` and `out_seed_ready` flip on the edge after `in_reseed`.
- Reset asserted mid-seed or mid-warmup returns to reset values on the next edge. Partially loaded seeds are discarded.

## Structure
- Add to `aes128_package`:
  - function `rand_lanes(num_shares, num_muls)`.
  - function `xorshift32_step`, shared by the RTL and the testbench model.
  - `typedef enum {RS_SEED, RS_WARMUP, RS_RUN} rand_state_t`.
- Reuse the existing `num_quad`.
- One sub-module, `xorshift32_lane`, with ports `in_load`, `in_seed`, `in_step`, `out_state`, `in_clock`, `in_reset`.
- The top level holds the FSM and counters, instantiates `NUM_LANES` lanes, and does the bit mapping.

## Test plan
- Reset, then `NUM_SHARES=2`, `NUM_MULS=1`, `WARMUP_CYCLES=1`: seed `32'h1` → `out_valid` high one cycle after acceptance. Lane = `32'h00042021`, so `out_r[0][0]=1` and `out_p[0][0]=0`.
- Seed word `32'h0` → lane loads `32'h1` and produces the same outputs as the previous scenario.
- `NUM_MULS=32` (2 lanes), default warmup: seed words arrive with a 3-cycle gap between them → `out_seed_ready` stays high until the 2nd acceptance. `out_valid` rises exactly 4 cycles later. Outputs match the package model.
- RUN with `in_enable` toggling 1,0,1 → masks change only after the enabled cycles and hold during the disabled one.
- `in_reseed` and `in_enable` high together in RUN → no step, `out_valid=0` and `out_seed_ready=1` next cycle, and reseeding with `32'h1` reproduces the first scenario.
- `in_reset` pulsed after one of two seed words → all lanes 0 and state SEED. A full reseed then behaves exactly like a fresh start.
